// File: rtl/latch_dump_sequencer_pkg.sv
// Shared debug-unit definitions: dump FSM states, word geometry, latch-mux sizing.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: dumpState_t (3-bit, IDLE=0), BYTES_PER_WORD, DBG_N_LATCH, DBG_SEL_W, topByte().
package latch_dump_sequencer_pkg;

  localparam int BYTES_PER_WORD = 4;
  // The debug unit and the latch mux are built from these same two numbers.
  localparam int DBG_N_LATCH    = 40;
  localparam int DBG_SEL_W      = 7;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    LOAD   = 3'd2,
    SEND   = 3'd3,
    WAIT   = 3'd4,
    DONE   = 3'd5
  } dumpState_t;

  // Words leave MSB-first, so the byte on the wire is always the top of the shifter.
  function automatic logic [7:0] topByte(input logic [31:0] word);
    return word[31:24];
  endfunction

endpackage

// File: rtl/latch_dump_sequencer_if.sv
// Bundles the dump sequencer's command, latch-mux and UART-TX signals.
// Latency: n/a (wires only).
// Backpressure: tx_start/tx_done pulse pair; sequencer holds tx_data until tx_done.
// Ports: start, abort, latch_data, tx_done -> sequencer; sel, tx_start, tx_data,
//        stop_pipe, busy, done <- sequencer. master = sequencer side, slave = environment.
interface latch_dump_sequencer_if
  import latch_dump_sequencer_pkg::*;
#(
  parameter int SEL_W = DBG_SEL_W
);

  logic             start;
  logic             abort;
  logic [31:0]      latch_data;
  logic             tx_done;
  logic [SEL_W-1:0] sel;
  logic             tx_start;
  logic [7:0]       tx_data;
  logic             stop_pipe;
  logic             busy;
  logic             done;

  modport master (
    input  start, abort, latch_data, tx_done,
    output sel, tx_start, tx_data, stop_pipe, busy, done
  );

  modport slave (
    output start, abort, latch_data, tx_done,
    input  sel, tx_start, tx_data, stop_pipe, busy, done
  );

endinterface

// File: rtl/latch_dump_sequencer.sv
// Freezes the pipeline and streams every latch word MSB-first as 4 UART bytes.
// Latency: first tx_start SETTLE_CYC+2 cycles after start; next byte 1 cycle after tx_done.
// Backpressure: waits indefinitely in WAIT for tx_done, holding tx_data, sel and stop_pipe.
// Ports: clk, rst (async, active-high); dbg (master modport): start/abort commands,
//        latch_data/sel to the latch mux, tx_start/tx_data/tx_done to UART TX, stop_pipe/busy/done status.
module latch_dump_sequencer
  import latch_dump_sequencer_pkg::*;
#(
  parameter int N_LATCH    = DBG_N_LATCH,  // 1..2**SEL_W
  parameter int SEL_W      = DBG_SEL_W,
  parameter int SETTLE_CYC = 2             // >= 1: registered mux latency + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  latch_dump_sequencer_if.master dbg
);

  localparam int               CNT_W       = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [SEL_W-1:0] SEL_LAST    = SEL_W'(N_LATCH - 1);
  localparam logic [1:0]       BYTE_LAST   = 2'(BYTES_PER_WORD - 1);

  dumpState_t       state;
  dumpState_t       nextState;
  logic [CNT_W-1:0] settleCnt;
  logic [1:0]       byteCnt;
  logic [31:0]      shiftReg;
  logic [31:0]      shiftNext;

  // Registered outputs and their next values.
  logic [SEL_W-1:0] selQ,      selNext;
  logic             txStartQ,  txStartNext;
  logic [7:0]       txDataQ,   txDataNext;
  logic             busyQ,     busyNext;
  logic             doneQ,     doneNext;

  // ---------------------------------------------------------------- state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    nextState = state;
    if (dbg.abort) begin
      // Abort beats everything, including a tx_done that would finish the dump.
      nextState = IDLE;
    end else begin
      case (state)
        IDLE:    if (dbg.start) nextState = SETTLE;
        SETTLE:  if (settleCnt == SETTLE_LAST) nextState = LOAD;
        LOAD:    nextState = SEND;
        SEND:    nextState = WAIT;
        WAIT: begin
          if (dbg.tx_done) begin
            if (byteCnt != BYTE_LAST)  nextState = SEND;
            else if (selQ == SEL_LAST) nextState = DONE;
            else                       nextState = SETTLE;
          end
        end
        DONE:    nextState = IDLE;
        default: nextState = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- outputs
  // Outputs are computed from nextState and registered, so each one lines up
  // with the state it belongs to rather than lagging it by a cycle.
  always_comb begin
    shiftNext   = shiftReg;
    selNext     = selQ;
    txDataNext  = txDataQ;
    txStartNext = (nextState == SEND);
    busyNext    = (nextState != IDLE);
    doneNext    = (nextState == DONE);

    if (state == LOAD && nextState == SEND) begin
      shiftNext = dbg.latch_data;
    end else if (state == WAIT && nextState == SEND) begin
      shiftNext = {shiftReg[23:0], 8'h00};
    end

    if (nextState == SEND) begin
      txDataNext = topByte(shiftNext);
    end

    if (nextState == IDLE) begin
      selNext = '0;
    end else if (state == WAIT && nextState == SETTLE) begin
      selNext = selQ + 1'b1;
    end
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      settleCnt <= '0;
      byteCnt   <= '0;
      shiftReg  <= '0;
      selQ      <= '0;
      txStartQ  <= 1'b0;
      txDataQ   <= 8'h00;
      busyQ     <= 1'b0;
      doneQ     <= 1'b0;
    end else begin
      // Counter restarts on every entry to SETTLE so each new sel gets the full settle time.
      if (nextState == SETTLE && state != SETTLE) begin
        settleCnt <= '0;
      end else if (state == SETTLE) begin
        settleCnt <= settleCnt + 1'b1;
      end

      if (nextState == SETTLE || nextState == IDLE) begin
        byteCnt <= '0;
      end else if (state == WAIT && nextState == SEND) begin
        byteCnt <= byteCnt + 1'b1;
      end

      shiftReg <= shiftNext;
      selQ     <= selNext;
      txStartQ <= txStartNext;
      txDataQ  <= txDataNext;
      busyQ    <= busyNext;
      doneQ    <= doneNext;
    end
  end

  assign dbg.sel       = selQ;
  assign dbg.tx_start  = txStartQ;
  assign dbg.tx_data   = txDataQ;
  assign dbg.stop_pipe = busyQ;
  assign dbg.busy      = busyQ;
  assign dbg.done      = doneQ;

endmodule

// File: tb/tb_latch_dump_sequencer.sv
// Directed bench for latch_dump_sequencer: a 2-word instance and a default 40-word instance.
// Latency: checks first-byte, inter-byte and inter-word timing against hand-computed cycles.
// Backpressure: holds tx_done low 1000 cycles and checks the sequencer stalls cleanly.
module tb_latch_dump_sequencer;
  import latch_dump_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  latch_dump_sequencer_if #(.SEL_W(7)) ifS ();
  latch_dump_sequencer_if #(.SEL_W(7)) ifF ();

  latch_dump_sequencer #(.N_LATCH(2),  .SEL_W(7), .SETTLE_CYC(2)) dutS (.clk(clk), .rst(rst), .dbg(ifS));
  latch_dump_sequencer #(.N_LATCH(40), .SEL_W(7), .SETTLE_CYC(2)) dutF (.clk(clk), .rst(rst), .dbg(ifF));

  // Latch mux models: small instance has two fixed words, large one repeats its sel in every byte.
  assign ifS.latch_data = (ifS.sel == 7'd0) ? 32'hA1B2C3D4 : 32'h01020304;
  assign ifF.latch_data = {4{1'b0, ifF.sel}};

  int nTests = 0;
  int nFail  = 0;

  logic [7:0] qS[$];
  logic [7:0] qF[$];
  int pendS = 0, pendF = 0, ackDlyS = 3, ackDlyF = 1;
  int doneCntS = 0, doneCntF = 0, busyCycS = 0, abortAt = -1;
  int errByteF = 0, errSelF = 0, selHeldF = 0;
  logic [6:0] prevSelF = 7'd0;

  typedef struct {
    int         cyc;
    logic       drvStart;
    logic       drvDone;
    logic       chkData;
    logic       chkSel;
    logic       expTxStart;
    logic [7:0] expTxData;
    logic [6:0] expSel;
    logic       expBusy;
    logic       expDone;
  } vec_t;

  localparam int NV = 24;
  vec_t tbl [0:NV-1];

  function automatic vec_t mk(int c, int s, int d, int cd, int cs, int ts, int td, int sl, int b, int dn);
    vec_t v;
    v.cyc = c; v.drvStart = s[0]; v.drvDone = d[0]; v.chkData = cd[0]; v.chkSel = cs[0];
    v.expTxStart = ts[0]; v.expTxData = 8'(td); v.expSel = 7'(sl); v.expBusy = b[0]; v.expDone = dn[0];
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // One clock: clear one-cycle pulses, run both UART responders and monitors.
  task automatic tick();
    int idx;
    @(posedge clk);
    #1;
    ifS.start = 1'b0; ifS.abort = 1'b0; ifS.tx_done = 1'b0;
    ifF.start = 1'b0; ifF.abort = 1'b0; ifF.tx_done = 1'b0;
    if (rst) begin
      pendS = 0;
      pendF = 0;
    end
    if (ifS.busy) busyCycS++;
    if (ifS.done) doneCntS++;
    if (pendS > 0) begin
      pendS--;
      if (pendS == 0) begin
        ifS.tx_done = 1'b1;
        if (qS.size() == abortAt) ifS.abort = 1'b1;
      end
    end
    if (ifS.tx_start) begin
      qS.push_back(ifS.tx_data);
      if (ackDlyS > 0) pendS = ackDlyS;
    end

    if (ifF.sel == prevSelF) selHeldF++;
    else selHeldF = 0;
    prevSelF = ifF.sel;
    if (ifF.done) doneCntF++;
    if (pendF > 0) begin
      pendF--;
      if (pendF == 0) ifF.tx_done = 1'b1;
    end
    if (ifF.tx_start) begin
      idx = qF.size();
      if (ifF.tx_data != 8'(idx / 4)) errByteF++;
      if (idx % 4 == 0 && (ifF.sel != 7'(idx / 4) || selHeldF < 3)) errSelF++;
      qF.push_back(ifF.tx_data);
      if (ackDlyF > 0) pendF = ackDlyF;
    end
  endtask

  logic [18:0] actV, expV;
  logic [7:0]  exp8 [0:7];
  logic [7:0]  holdData;
  logic [6:0]  holdSel;
  int cur, n, badData, badSel, badPipe, nBytes;

  initial begin
    rst = 1'b1;
    ifS.start = 1'b0; ifS.abort = 1'b0; ifS.tx_done = 1'b0;
    ifF.start = 1'b0; ifF.abort = 1'b0; ifF.tx_done = 1'b0;
    exp8[0] = 8'hA1; exp8[1] = 8'hB2; exp8[2] = 8'hC3; exp8[3] = 8'hD4;
    exp8[4] = 8'h01; exp8[5] = 8'h02; exp8[6] = 8'h03; exp8[7] = 8'h04;

    tbl[0]  = mk(0,  1, 0, 1, 1, 0, 'h00, 0, 0, 0);
    tbl[1]  = mk(1,  0, 0, 0, 1, 0, 'h00, 0, 1, 0);
    tbl[2]  = mk(3,  0, 0, 0, 1, 0, 'h00, 0, 1, 0);
    tbl[3]  = mk(4,  0, 0, 1, 1, 1, 'hA1, 0, 1, 0);
    tbl[4]  = mk(5,  0, 0, 1, 1, 0, 'hA1, 0, 1, 0);
    tbl[5]  = mk(7,  0, 0, 1, 1, 0, 'hA1, 0, 1, 0);
    tbl[6]  = mk(8,  0, 0, 1, 1, 1, 'hB2, 0, 1, 0);
    tbl[7]  = mk(12, 0, 0, 1, 1, 1, 'hC3, 0, 1, 0);
    tbl[8]  = mk(16, 0, 0, 1, 1, 1, 'hD4, 0, 1, 0);
    tbl[9]  = mk(19, 0, 0, 1, 1, 0, 'hD4, 0, 1, 0);
    tbl[10] = mk(20, 0, 0, 0, 1, 0, 'h00, 1, 1, 0);
    tbl[11] = mk(22, 0, 0, 0, 1, 0, 'h00, 1, 1, 0);
    tbl[12] = mk(23, 0, 0, 1, 1, 1, 'h01, 1, 1, 0);
    tbl[13] = mk(27, 0, 0, 1, 1, 1, 'h02, 1, 1, 0);
    tbl[14] = mk(31, 0, 0, 1, 1, 1, 'h03, 1, 1, 0);
    tbl[15] = mk(35, 0, 0, 1, 1, 1, 'h04, 1, 1, 0);
    tbl[16] = mk(38, 0, 0, 1, 1, 0, 'h04, 1, 1, 0);
    tbl[17] = mk(39, 0, 0, 0, 0, 0, 'h00, 0, 1, 1);
    tbl[18] = mk(40, 1, 0, 0, 1, 0, 'h00, 0, 0, 0);
    tbl[19] = mk(41, 0, 1, 0, 1, 0, 'h00, 0, 1, 0);
    tbl[20] = mk(43, 0, 1, 0, 1, 0, 'h00, 0, 1, 0);
    tbl[21] = mk(44, 0, 0, 1, 1, 1, 'hA1, 0, 1, 0);
    tbl[22] = mk(50, 1, 0, 1, 1, 0, 'hB2, 0, 1, 0);
    tbl[23] = mk(52, 0, 0, 1, 1, 1, 'hC3, 0, 1, 0);

    // Reset state of both instances.
    tick();
    tick();
    check("reset_S", {ifS.sel, ifS.tx_start, ifS.tx_data, ifS.stop_pipe, ifS.busy, ifS.done}, 64'd0);
    check("reset_F", {ifF.sel, ifF.tx_start, ifF.tx_data, ifF.stop_pipe, ifF.busy, ifF.done}, 64'd0);
    #2 rst = 1'b0;
    tick();
    busyCycS = 0;

    // Two back-to-back dumps on the 2-word instance; spurious tx_done/start in the second.
    cur = 0;
    for (int i = 0; i < NV; i++) begin
      while (cur < tbl[i].cyc) begin
        tick();
        cur++;
      end
      actV = {ifS.tx_start, tbl[i].chkData ? ifS.tx_data : 8'h00, tbl[i].chkSel ? ifS.sel : 7'h00,
              ifS.stop_pipe, ifS.busy, ifS.done};
      expV = {tbl[i].expTxStart, tbl[i].chkData ? tbl[i].expTxData : 8'h00,
              tbl[i].chkSel ? tbl[i].expSel : 7'h00, tbl[i].expBusy, tbl[i].expBusy, tbl[i].expDone};
      check($sformatf("vec_cyc%0d", tbl[i].cyc), 64'(actV), 64'(expV));
      if (tbl[i].drvStart) ifS.start = 1'b1;
      if (tbl[i].drvDone)  ifS.tx_done = 1'b1;
    end

    n = 0;
    while (doneCntS < 2 && n < 200) begin
      tick();
      n++;
    end
    check("second_done_seen", 64'(doneCntS), 64'd2);
    check("busy_cycles_two_dumps", 64'(busyCycS), 64'd78);
    check("byte_count_two_dumps", 64'(qS.size()), 64'd16);
    nBytes = (qS.size() < 16) ? qS.size() : 16;
    for (int i = 0; i < nBytes; i++) check($sformatf("byte%0d", i), 64'(qS[i]), 64'(exp8[i % 8]));

    // Back-pressure: no auto-ack for the first byte of the third dump.
    ackDlyS = 0;
    tick();
    ifS.start = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!ifS.tx_start && n < 20);
    check("first_txstart_latency", 64'(n), 64'd4);
    check("bp_first_byte", 64'(ifS.tx_data), 64'hA1);
    holdData = ifS.tx_data;
    holdSel  = ifS.sel;
    badData = 0; badSel = 0; badPipe = 0;
    for (int k = 0; k < 1000; k++) begin
      tick();
      if (ifS.tx_data != holdData) badData++;
      if (ifS.sel != holdSel) badSel++;
      if (!ifS.stop_pipe) badPipe++;
    end
    check("bp_txdata_stable", 64'(badData), 64'd0);
    check("bp_sel_stable", 64'(badSel), 64'd0);
    check("bp_stop_pipe_held", 64'(badPipe), 64'd0);
    check("bp_no_extra_start", 64'(qS.size()), 64'd17);

    // Release, then abort together with the tx_done of the final byte.
    ackDlyS = 1;
    abortAt = 24;
    ifS.tx_done = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!ifS.abort && n < 200);
    check("abort_reached", 64'(ifS.abort), 64'd1);
    check("abort_last_byte", 64'(qS.size() == 24 ? qS[23] : 8'hFF), 64'h04);
    tick();
    abortAt = -1;
    check("abort_idle_next", {ifS.sel, ifS.tx_start, ifS.stop_pipe, ifS.busy, ifS.done}, 64'd0);
    for (int k = 0; k < 10; k++) tick();
    check("abort_no_done", 64'(doneCntS), 64'd2);

    // Full instance: reset mid-dump during WAIT of word 5.
    ifF.start = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!(ifF.tx_start && ifF.sel == 7'd5) && n < 300);
    tick();
    check("f_in_wait_word5", {ifF.sel, ifF.tx_start, ifF.busy}, {7'd5, 1'b0, 1'b1});
    #2 rst = 1'b1;
    #1;
    check("rst_async_F", {ifF.sel, ifF.tx_start, ifF.tx_data, ifF.stop_pipe, ifF.busy, ifF.done}, 64'd0);
    tick();
    tick();
    #2 rst = 1'b0;
    tick();
    check("f_idle_after_rst", {ifF.sel, ifF.busy, ifF.tx_start}, 64'd0);

    // Full default dump from sel 0.
    qF.delete();
    errByteF = 0; errSelF = 0; doneCntF = 0;
    ifF.start = 1'b1;
    n = 0;
    while (doneCntF < 1 && n < 1000) begin
      tick();
      n++;
    end
    check("f_done_seen", 64'(doneCntF), 64'd1);
    check("f_tx_start_count", 64'(qF.size()), 64'd160);
    check("f_byte_order", 64'(errByteF), 64'd0);
    check("f_sel_seq_and_settle", 64'(errSelF), 64'd0);
    tick();
    tick();
    check("f_final_idle", {ifF.busy, ifF.stop_pipe, ifF.sel, 32'(doneCntF)}, {1'b0, 1'b0, 7'd0, 32'd1});

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
